// File: rtl/button_event_if.sv
// Event bundle between the debounced button level and the control logic.
// button_event uses the slave side; the consumer/driver uses master.
interface button_event_if;
  logic       clean;
  logic       press;
  logic       release_pulse;
  logic       long_press;
  logic       repeat_pulse;
  logic       held;
  logic [7:0] press_cnt;

  modport master (
    output clean,
    input  press, release_pulse, long_press, repeat_pulse, held, press_cnt
  );

  modport slave (
    input  clean,
    output press, release_pulse, long_press, repeat_pulse, held, press_cnt
  );
endinterface

// File: rtl/button_event.sv
// Turns the debounced button level into single-cycle press, release,
// long-press and auto-repeat pulses, plus a held level and a press counter.
module button_event #(
  parameter int unsigned LONG_DELAY    = 6500000,
  parameter int unsigned REPEAT_PERIOD = 1000000,
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned NBITS         = 24
) (
  input  logic          clks,
  input  logic          rst_n,
  button_event_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    LONG = 2'd2
  } state_t;

  localparam logic [NBITS-1:0] LONG_LAST = NBITS'(LONG_DELAY - 1);
  localparam logic [NBITS-1:0] REP_LAST  = NBITS'(REPEAT_PERIOD - 1);

  state_t           state, next_state;
  logic [NBITS-1:0] count, next_count;
  logic             press_d, release_d, long_d, repeat_d;

  always_ff @(posedge clks or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      count             <= '0;
      bus.press         <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.long_press    <= 1'b0;
      bus.repeat_pulse  <= 1'b0;
      bus.held          <= 1'b0;
      bus.press_cnt     <= '0;
    end else begin
      state             <= next_state;
      count             <= next_count;
      bus.press         <= press_d;
      bus.release_pulse <= release_d;
      bus.long_press    <= long_d;
      bus.repeat_pulse  <= repeat_d;
      bus.held          <= (next_state != IDLE);
      if (press_d) bus.press_cnt <= bus.press_cnt + 8'd1;
    end
  end

  // Release is tested before the terminal count, so it wins on a coincident edge.
  always_comb begin
    next_state = state;
    next_count = count;
    case (state)
      IDLE: begin
        next_count = '0;
        if (bus.clean) next_state = HOLD;
      end
      HOLD: begin
        if (!bus.clean) begin
          next_state = IDLE;
          next_count = '0;
        end else if (count == LONG_LAST) begin
          next_state = LONG;
          next_count = '0;
        end else begin
          next_count = count + NBITS'(1);
        end
      end
      LONG: begin
        if (!bus.clean) begin
          next_state = IDLE;
          next_count = '0;
        end else if (count == REP_LAST) begin
          next_count = '0;
        end else begin
          next_count = count + NBITS'(1);
        end
      end
      default: begin
        next_state = IDLE;
        next_count = '0;
      end
    endcase
  end

  always_comb begin
    press_d   = (state == IDLE) && bus.clean;
    release_d = (state != IDLE) && !bus.clean;
    long_d    = (state == HOLD) && bus.clean && (count == LONG_LAST);
    repeat_d  = (REPEAT_EN != 0) && (state == LONG) && bus.clean && (count == REP_LAST);
  end

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event: one instance with repeat enabled and one
// with it disabled, both fed the same button level.
module tb_button_event;
  logic clks  = 1'b0;
  logic rst_n = 1'b0;
  logic clean = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 1'b0;
  int   reps;

  button_event_if ifa ();
  button_event_if ifb ();

  assign ifa.clean = clean;
  assign ifb.clean = clean;

  button_event #(.LONG_DELAY(10), .REPEAT_PERIOD(4), .REPEAT_EN(1), .NBITS(8)) dut_a (
    .clks (clks), .rst_n(rst_n), .bus(ifa.slave)
  );
  button_event #(.LONG_DELAY(10), .REPEAT_PERIOD(4), .REPEAT_EN(0), .NBITS(8)) dut_b (
    .clks (clks), .rst_n(rst_n), .bus(ifb.slave)
  );

  always #5 clks = ~clks;

  // {press, release, long_press, repeat, held}
  logic [4:0] obs_a, obs_b;
  assign obs_a = {ifa.press, ifa.release_pulse, ifa.long_press, ifa.repeat_pulse, ifa.held};
  assign obs_b = {ifb.press, ifb.release_pulse, ifb.long_press, ifb.repeat_pulse, ifb.held};

  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clks) begin
    if (!done) begin
      n_checks++;
      assert (($onehot0(obs_a[4:1]) && $onehot0(obs_b[4:1])) === 1'b1) else begin
        n_fail++;
        $error("FAIL onehot: observed a=%b b=%b expected at most one pulse each", obs_a[4:1], obs_b[4:1]);
      end
    end
  end

  task automatic step();
    @(posedge clks);
    #1;
  endtask

  task automatic idle(input int k, input string tag);
    clean = 1'b0;
    for (int i = 0; i < k; i++) begin
      step();
      chk5({tag, " idle a"}, obs_a, 5'b00000);
      chk5({tag, " idle b"}, obs_b, 5'b00000);
    end
  endtask

  // Hold for n cycles: press at e1, long_press at e11 (if still held),
  // repeat every 4 edges after that (instance a only), release at e(n+1).
  task automatic hold_seq(input int n, input string tag, output int nrep);
    logic [4:0] ea, eb;
    nrep  = 0;
    clean = 1'b1;
    for (int e = 1; e <= n + 1; e++) begin
      step();
      ea = {e == 1, e == n + 1, (e == 11) && (e <= n),
            (e > 11) && (e <= n) && ((e - 11) % 4 == 0), e <= n};
      eb = {ea[4:2], 1'b0, ea[0]};
      chk5($sformatf("%s a e%0d", tag, e), obs_a, ea);
      chk5($sformatf("%s b e%0d", tag, e), obs_b, eb);
      if (ifa.repeat_pulse) nrep++;
      if (e == n) clean = 1'b0;
    end
  endtask

  initial begin
    // Reset state, including a held button while in reset
    repeat (2) step();
    chk5("reset a", obs_a, 5'b00000);
    chk8("reset cnt a", ifa.press_cnt, 8'd0);
    clean = 1'b1;
    step();
    chk5("reset clean a", obs_a, 5'b00000);
    chk5("reset clean b", obs_b, 5'b00000);
    clean = 1'b0;
    @(negedge clks);
    rst_n = 1'b1;
    idle(2, "post-reset");

    hold_seq(5, "short", reps);
    chk8("short cnt", ifa.press_cnt, 8'd1);
    idle(2, "short");

    hold_seq(25, "long", reps);
    chk8("long reps", 8'(reps), 8'd3);
    chk8("long cnt", ifb.press_cnt, 8'd2);
    idle(2, "long");

    hold_seq(10, "coinc_long", reps);
    chk8("coinc_long cnt", ifa.press_cnt, 8'd3);
    idle(1, "coinc_long");

    hold_seq(14, "coinc_rep", reps);
    chk8("coinc_rep reps", 8'(reps), 8'd0);
    idle(1, "coinc_rep");

    // Glitch 1-0-1-0 on consecutive edges
    clean = 1'b1; step(); chk5("glitch e1", obs_a, 5'b10001);
    clean = 1'b0; step(); chk5("glitch e2", obs_a, 5'b01000);
    clean = 1'b1; step(); chk5("glitch e3", obs_a, 5'b10001);
    clean = 1'b0; step(); chk5("glitch e4", obs_a, 5'b01000);
    chk8("glitch cnt", ifa.press_cnt, 8'd6);
    idle(1, "glitch");

    // Async reset in the middle of LONG, release with the button still held
    clean = 1'b1;
    repeat (13) step();
    chk5("preRST long a", obs_a, 5'b00001);
    chk8("preRST cnt", ifa.press_cnt, 8'd7);
    #3 rst_n = 1'b0;
    #1;
    chk5("async rst a", obs_a, 5'b00000);
    chk5("async rst b", obs_b, 5'b00000);
    chk8("async rst cnt", ifa.press_cnt, 8'd0);
    step();
    chk5("in rst a", obs_a, 5'b00000);
    @(negedge clks);
    rst_n = 1'b1;
    step();
    chk5("rst exit press", obs_a, 5'b10001);
    chk8("rst exit cnt", ifa.press_cnt, 8'd1);
    step();
    chk5("rst exit hold", obs_a, 5'b00001);
    clean = 1'b0;
    step();
    chk5("rst exit release", obs_a, 5'b01000);
    idle(1, "rst");

    // press_cnt wrap: 254 more presses to 255, then one more to 0
    for (int i = 0; i < 254; i++) begin
      clean = 1'b1; step();
      clean = 1'b0; step();
    end
    chk8("cnt 255", ifa.press_cnt, 8'd255);
    clean = 1'b1;
    step();
    chk5("wrap press", obs_a, 5'b10001);
    chk8("cnt wrap a", ifa.press_cnt, 8'd0);
    chk8("cnt wrap b", ifb.press_cnt, 8'd0);
    clean = 1'b0;
    step();
    chk5("wrap release", obs_a, 5'b01000);

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
